// File: rtl/sample_pipe_if.sv
// rtl/sample_pipe_if.sv - control, random-input and result bundle for sample_pipe
// The master side drives control and random beats; the slave side is the sampler.
interface sample_pipe_if #(
  parameter int BIT_WID    = 8,
  parameter int NUM_STATES = 32,
  parameter int RESULT_W   = $clog2(NUM_STATES),
  parameter int LANES      = 4,
  parameter int LEN_W      = 16
);
  logic                          distr_load;
  logic [BIT_WID*NUM_STATES-1:0] distr_data;
  logic                          start;
  logic [LEN_W-1:0]              batch_len;
  logic                          rand_valid;
  logic                          rand_ready;
  logic [LANES*BIT_WID-1:0]      rand_data;
  logic                          res_valid;
  logic                          res_ready;
  logic [LANES*RESULT_W-1:0]     res_data;
  logic                          busy;
  logic                          done;

  modport master (
    output distr_load, distr_data, start, batch_len, rand_valid, rand_data, res_ready,
    input  rand_ready, res_valid, res_data, busy, done
  );

  modport slave (
    input  distr_load, distr_data, start, batch_len, rand_valid, rand_data, res_ready,
    output rand_ready, res_valid, res_data, busy, done
  );
endinterface

// File: rtl/sample_pipe.sv
// rtl/sample_pipe.sv - pipelined multi-lane inverse-CDF sampler with batch control
// Each lane counts the CDF entries its random value exceeds, saturated to NUM_STATES-1.
module sample_pipe #(
  parameter int BIT_WID    = 8,
  parameter int NUM_STATES = 32,
  parameter int RESULT_W   = $clog2(NUM_STATES),
  parameter int LANES      = 4,
  parameter int LEN_W      = 16
) (
  input  logic         clk,
  input  logic         rst,
  sample_pipe_if.slave bus
);
  localparam int P     = 1 << $clog2(NUM_STATES);
  localparam int CNT_W = $clog2(NUM_STATES + 1);
  localparam logic [CNT_W-1:0]    MAX_CNT = CNT_W'(NUM_STATES - 1);
  localparam logic [RESULT_W-1:0] MAX_RES = RESULT_W'(NUM_STATES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t                        r_state;
  state_t                        w_state_nx;
  logic [BIT_WID*NUM_STATES-1:0] r_distr;
  logic [LEN_W-1:0]              r_len;
  logic [LEN_W-1:0]              r_issued;
  logic                          r_s1_valid;
  logic [LANES*BIT_WID-1:0]      r_s1_data;
  logic                          r_s2_valid;
  logic [LANES*RESULT_W-1:0]     r_s2_data;
  logic [LANES*RESULT_W-1:0]     w_res;
  logic                          w_adv;
  logic                          w_rand_ready;
  logic                          w_accept;
  logic                          w_last;
  logic                          w_drained;

  assign w_adv        = !r_s2_valid || bus.res_ready;
  assign w_rand_ready = (r_state == ST_RUN) && w_adv && (r_issued < r_len);
  assign w_accept     = bus.rand_valid && w_rand_ready;
  assign w_last       = w_accept && ((r_issued + LEN_W'(1)) == r_len);
  // Pipeline empties at this edge: S1 idle and S2 either idle or being taken now.
  assign w_drained    = !r_s1_valid && (!r_s2_valid || bus.res_ready);

  assign bus.rand_ready = w_rand_ready;
  assign bus.res_valid  = r_s2_valid;
  assign bus.res_data   = r_s2_data;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.done       = (r_state == ST_DONE);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [CNT_W-1:0] w_cnt;

    // Heap-ordered balanced tree: leaves at P-1.., padding leaves stay zero.
    always_comb begin
      logic [CNT_W-1:0] tree [2*P-1];
      for (int i = 0; i < 2*P-1; i++) tree[i] = '0;
      for (int j = 0; j < NUM_STATES; j++)
        tree[P-1+j] = CNT_W'(r_s1_data[k*BIT_WID +: BIT_WID] > r_distr[j*BIT_WID +: BIT_WID]);
      for (int i = P-2; i >= 0; i--)
        tree[i] = tree[2*i+1] + tree[2*i+2];
      w_cnt = tree[0];
    end

    assign w_res[k*RESULT_W +: RESULT_W] = (w_cnt > MAX_CNT) ? MAX_RES : w_cnt[RESULT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_state_nx = (bus.batch_len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (w_last) w_state_nx = ST_DRAIN;
      ST_DRAIN: if (w_drained) w_state_nx = ST_DONE;
      ST_DONE:  w_state_nx = ST_IDLE;
      default:  w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_distr    <= '1;
      r_len      <= '0;
      r_issued   <= '0;
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
    end else begin
      if (r_state == ST_IDLE) begin
        if (bus.distr_load) r_distr <= bus.distr_data;
        if (bus.start) begin
          r_len    <= bus.batch_len;
          r_issued <= '0;
        end
      end
      if (w_accept) r_issued <= r_issued + LEN_W'(1);
      // Both stages freeze together on a downstream stall, so res_data holds.
      if (w_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) r_s2_data <= w_res;
        r_s1_valid <= w_accept;
        if (w_accept) r_s1_data <= bus.rand_data;
      end
    end
  end
endmodule

// File: tb/tb_sample_pipe.sv
// tb/tb_sample_pipe.sv - directed bench for sample_pipe with a transaction-level reference model
// The model tracks batch phase, frozen CDF and an expected-result queue at the handshake level.
module tb_sample_pipe;
  localparam int BW = 8;
  localparam int NS = 32;
  localparam int RW = $clog2(NS);
  localparam int LN = 4;
  localparam int LW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sample_pipe_if #(.BIT_WID(BW), .NUM_STATES(NS), .RESULT_W(RW), .LANES(LN), .LEN_W(LW)) bus();
  sample_pipe #(.BIT_WID(BW), .NUM_STATES(NS), .RESULT_W(RW), .LANES(LN), .LEN_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stalls = 0;
  int res_count = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NS*BW-1:0] cdf_uniform();
    logic [NS*BW-1:0] c;
    for (int j = 0; j < NS; j++) c[j*BW +: BW] = BW'(8*j + 7);
    return c;
  endfunction

  function automatic logic [NS*BW-1:0] cdf_ident();
    logic [NS*BW-1:0] c;
    for (int j = 0; j < NS; j++) c[j*BW +: BW] = BW'(j);
    return c;
  endfunction

  function automatic logic [LN*RW-1:0] model(input logic [LN*BW-1:0] r, input logic [NS*BW-1:0] cdf);
    logic [LN*RW-1:0] o;
    for (int k = 0; k < LN; k++) begin
      int c = 0;
      for (int j = 0; j < NS; j++)
        if (r[k*BW +: BW] > cdf[j*BW +: BW]) c++;
      if (c > NS - 1) c = NS - 1;
      o[k*RW +: RW] = RW'(c);
    end
    return o;
  endfunction

  bit               m_idle, m_done, m_hold;
  int               m_rem;
  logic [NS*BW-1:0] m_cdf;
  logic [LN*RW-1:0] m_prev, m_exp;
  logic [LN*RW-1:0] exp_q[$];
  logic             m_rr, m_acc, m_cons;

  // Single compare process: checks this cycle, then advances the model over the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      m_idle = 1'b1; m_done = 1'b0; m_hold = 1'b0; m_rem = 0;
      m_cdf = '1; exp_q.delete();
    end else begin
      chk("busy", bus.busy, !m_idle);
      chk("done", bus.done, m_done);
      m_rr = !m_idle && !m_done && (m_rem > 0) && (!bus.res_valid || bus.res_ready);
      chk("rand_ready", bus.rand_ready, m_rr);
      if (m_hold) begin
        chk("hold_valid", bus.res_valid, 1);
        chk("hold_data", bus.res_data, m_prev);
      end
      m_acc  = bus.rand_valid && m_rr;
      m_cons = 1'b0;
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) chk("spurious_res_valid", 1, 0);
        else begin
          m_exp = exp_q.pop_front();
          chk("res_data", bus.res_data, m_exp);
          m_cons = 1'b1;
          res_count++;
        end
      end
      if (bus.res_valid && !bus.res_ready) stalls++;
      m_hold = bus.res_valid && !bus.res_ready;
      m_prev = bus.res_data;
      if (m_done) begin
        m_done = 1'b0;
        m_idle = 1'b1;
      end else if (m_idle) begin
        if (bus.distr_load) m_cdf = bus.distr_data;
        if (bus.start) begin
          m_idle = 1'b0;
          m_rem  = int'(bus.batch_len);
          if (bus.batch_len == 0) m_done = 1'b1;
        end
      end else begin
        if (m_acc) begin
          exp_q.push_back(model(bus.rand_data, m_cdf));
          m_rem--;
        end
        if (m_cons && m_rem == 0 && exp_q.size() == 0) m_done = 1'b1;
      end
    end
  end

  int t_start, t_acc, t_res, t_done;
  logic [LN*RW-1:0] r_got;

  task automatic load_cdf(input logic [NS*BW-1:0] c);
    @(posedge clk); #1;
    bus.distr_load = 1'b1; bus.distr_data = c;
    @(posedge clk); #1;
    bus.distr_load = 1'b0;
  endtask

  task automatic start_batch(input int len);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.batch_len = LW'(len); t_start = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_accept(output int t);
    t = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.rand_valid && bus.rand_ready) begin t = cyc; break; end
    end
    if (t < 0) chk("timeout_accept", 0, 1);
  endtask

  task automatic wait_res(output logic [LN*RW-1:0] d, output int t);
    t = -1; d = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.res_valid) begin d = bus.res_data; t = cyc; break; end
    end
    if (t < 0) chk("timeout_res", 0, 1);
  endtask

  task automatic wait_done(output int t);
    t = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.done) begin t = cyc; break; end
    end
    if (t < 0) chk("timeout_done", 0, 1);
  endtask

  logic [7:0]       tbl [8] = '{8'h00, 8'h01, 8'h1f, 8'h20, 8'h80, 8'hfe, 8'hff, 8'h55};
  logic [3:0]       pat = 4'b1001;
  logic [LN*BW-1:0] beat;
  int               s0, c0;

  initial begin
    rst = 1'b1;
    bus.distr_load = 1'b0; bus.distr_data = '0; bus.start = 1'b0; bus.batch_len = '0;
    bus.rand_valid = 1'b0; bus.rand_data = '0; bus.res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_rand_ready", bus.rand_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);

    // Uniform CDF, one beat, latency and completion timing.
    load_cdf(cdf_uniform());
    bus.rand_data = {8'hFF, 8'h7F, 8'h08, 8'h00};
    bus.rand_valid = 1'b1;
    start_batch(1);
    wait_accept(t_acc);
    wait_res(r_got, t_res);
    chk("t1_data", r_got, {5'd31, 5'd15, 5'd1, 5'd0});
    chk("t1_latency", t_res - t_acc, 2);
    wait_done(t_done);
    chk("t1_done_time", t_done - t_start, 4);

    // Saturation: value above every entry.
    load_cdf(cdf_ident());
    bus.rand_data = {4{8'hFF}};
    start_batch(1);
    wait_res(r_got, t_res);
    chk("t2_saturate", r_got, {4{5'd31}});
    wait_done(t_done);

    // Backpressure with a 1,0,0,1 ready pattern and changing data.
    s0 = stalls; c0 = res_count; t_done = -1;
    start_batch(8);
    for (int i = 0; i < 200; i++) begin
      bus.res_ready = pat[i%4];
      for (int k = 0; k < LN; k++) beat[k*BW +: BW] = tbl[(i+k)%8];
      bus.rand_data = beat;
      @(negedge clk);
      if (bus.done) begin t_done = cyc; break; end
      @(posedge clk); #1;
    end
    bus.res_ready = 1'b1;
    if (t_done < 0) chk("timeout_t3", 0, 1);
    chk("t3_count", res_count - c0, 8);
    chk("t3_done_time", t_done - t_start, 11 + (stalls - s0));

    // Load during a batch is ignored; load in idle takes effect.
    load_cdf(cdf_uniform());
    bus.rand_data = {4{8'h10}};
    start_batch(2);
    load_cdf(cdf_ident());
    wait_res(r_got, t_res);
    chk("t4_frozen", r_got, {4{5'd2}});
    wait_done(t_done);
    load_cdf(cdf_ident());
    start_batch(1);
    wait_res(r_got, t_res);
    chk("t4_new_cdf", r_got, {4{5'd16}});
    wait_done(t_done);

    // Zero-length batch, then a start pulse while busy.
    start_batch(0);
    @(negedge clk);
    chk("t5_done_pulse", bus.done, 1);
    chk("t5_no_ready", bus.rand_ready, 0);
    @(negedge clk);
    chk("t5_done_drop", bus.done, 0);
    c0 = res_count;
    start_batch(2);
    bus.start = 1'b1; bus.batch_len = LW'(5);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(t_done);
    chk("t5_busy_start_ignored", res_count - c0, 2);
    repeat (4) @(negedge clk);

    // Reset with two beats stalled in the pipe.
    bus.res_ready = 1'b0;
    start_batch(4);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_res_valid", bus.res_valid, 0);
    chk("t6_res_data", bus.res_data, 0);
    chk("t6_rand_ready", bus.rand_ready, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_done", bus.done, 0);
    bus.res_ready = 1'b1;
    repeat (6) @(negedge clk);
    bus.rand_data = {4{8'hFF}};
    start_batch(1);
    wait_res(r_got, t_res);
    chk("t6_cdf_reset", r_got, 0);
    wait_done(t_done);
    bus.rand_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
